// File: rtl/fsm_pkg.sv
// State encoding shared by the sequence-detector family of blocks.
package fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/window_timer.sv
// Free-running window timer: counts 0 .. WINDOW-1 while enabled, flags the last cycle.
module window_timer #(
  parameter int WIN_W  = 16,
  parameter int WINDOW = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam logic [WIN_W-1:0] LAST_VAL = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] timer;

  assign last = (timer == LAST_VAL);

  // Wraps straight back to 0 after the last cycle so windows abut with no gap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= last ? '0 : timer + WIN_W'(1);
    end
  end

endmodule

// File: rtl/match_rate_monitor.sv
// Counts Match pulses per fixed window, posts each window count through a
// one-deep valid/ready register and raises Alarm when a window reaches THRESH.
module match_rate_monitor #(
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 16,
  parameter int WINDOW = 1000,
  parameter int THRESH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Match,
  input  logic             Enable,
  input  logic             Rd_Ready,
  output logic             Rd_Valid,
  output logic [CNT_W-1:0] Rd_Count,
  output logic             Rd_Drop,
  output logic             Alarm
);

  import fsm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             run_en;
  logic             tmr_last;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] closing;
  logic             close_evt;
  logic             load_evt;
  logic             xfer_evt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable)  state_nxt = RUN;
      RUN:     if (!Enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counting happens only on edges that stay in RUN; the entry edge is not counted.
  always_comb begin
    run_en = (state == RUN) && Enable;
  end

  window_timer #(
    .WIN_W  (WIN_W),
    .WINDOW (WINDOW)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .en   (run_en),
    .clr  (!run_en),
    .last (tmr_last)
  );

  assign closing   = (Match && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
  assign close_evt = run_en && tmr_last;
  assign xfer_evt  = Rd_Valid && Rd_Ready;
  assign load_evt  = close_evt && (!Rd_Valid || Rd_Ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (!run_en || tmr_last) begin
      count <= '0;
    end else begin
      count <= closing;
    end
  end

  // A close that finds the register full and unaccepted loses its value and marks Rd_Drop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Rd_Valid <= 1'b0;
      Rd_Count <= '0;
      Rd_Drop  <= 1'b0;
      Alarm    <= 1'b0;
    end else begin
      if (load_evt) begin
        Rd_Valid <= 1'b1;
        Rd_Count <= closing;
      end else if (xfer_evt) begin
        Rd_Valid <= 1'b0;
      end
      if (close_evt && !load_evt) begin
        Rd_Drop <= 1'b1;
      end
      if (close_evt) begin
        Alarm <= (int'(closing) >= THRESH);
      end
    end
  end

endmodule

// File: tb/tb_match_rate_monitor.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run checked against a window-level reference model.
module tb_match_rate_monitor;

  localparam int WIN  = 10;
  localparam int THR  = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Match;
  logic          Enable;
  logic          Rd_Ready;
  logic          Rd_Valid;
  logic [CW-1:0] Rd_Count;
  logic          Rd_Drop;
  logic          Alarm;
  logic          satValid;
  logic [CW-1:0] satCount;
  logic          satDrop;
  logic          satAlarm;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: whole-window view of the monitor.
  bit mRunning;
  int mPos;
  int mHits;
  bit mValid;
  int mCount;
  bit mDrop;
  bit mAlarm;

  typedef struct {
    logic m;
    logic e;
    logic r;
    logic expValid;
    int   expCount;
    logic expAlarm;
  } vec_t;

  vec_t vecs[$];

  match_rate_monitor #(.CNT_W(CW), .WIN_W(16), .WINDOW(WIN), .THRESH(THR)) dut (
    .CLK(CLK), .RST(RST), .Match(Match), .Enable(Enable), .Rd_Ready(Rd_Ready),
    .Rd_Valid(Rd_Valid), .Rd_Count(Rd_Count), .Rd_Drop(Rd_Drop), .Alarm(Alarm)
  );

  match_rate_monitor #(.CNT_W(CW), .WIN_W(16), .WINDOW(20), .THRESH(THR)) dutSat (
    .CLK(CLK), .RST(RST), .Match(Match), .Enable(Enable), .Rd_Ready(Rd_Ready),
    .Rd_Valid(satValid), .Rd_Count(satCount), .Rd_Drop(satDrop), .Alarm(satAlarm)
  );

  always #5 CLK = ~CLK;

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".valid"}, int'(Rd_Valid), int'(mValid));
    checkValue({tag, ".count"}, int'(Rd_Count), mCount);
    checkValue({tag, ".drop"},  int'(Rd_Drop),  int'(mDrop));
    checkValue({tag, ".alarm"}, int'(Alarm),    int'(mAlarm));
  endtask

  function automatic void modelReset();
    mRunning = 0; mPos = 0; mHits = 0;
    mValid = 0; mCount = 0; mDrop = 0; mAlarm = 0;
  endfunction

  function automatic void modelStep(input bit m, input bit e, input bit r);
    int closeVal;
    if (mRunning && e && mPos == WIN - 1) begin
      closeVal = (mHits + int'(m) > CMAX) ? CMAX : mHits + int'(m);
      mAlarm = (closeVal >= THR);
      if (!mValid || r) begin
        mValid = 1;
        mCount = closeVal;
      end else begin
        mDrop = 1;
      end
    end else if (mValid && r) begin
      mValid = 0;
    end
    if (mRunning && e) begin
      if (mPos == WIN - 1) begin
        mPos = 0; mHits = 0;
      end else begin
        mPos++;
        mHits = (mHits + int'(m) > CMAX) ? CMAX : mHits + int'(m);
      end
    end else begin
      mRunning = e; mPos = 0; mHits = 0;
    end
  endfunction

  task automatic applyStimulus(input logic m, input logic e, input logic r);
    Match = m; Enable = e; Rd_Ready = r;
    @(posedge CLK);
    modelStep(m, e, r);
    #1;
    checkOutput("model");
  endtask

  // Asserts reset between edges; leaves inputs idle and the bench at edge+1.
  task automatic doReset();
    Match = 0; Enable = 0; Rd_Ready = 0;
    RST = 1;
    #1;
    modelReset();
    checkValue("rst.valid", int'(Rd_Valid), 0);
    checkValue("rst.count", int'(Rd_Count), 0);
    checkValue("rst.drop",  int'(Rd_Drop),  0);
    checkValue("rst.alarm", int'(Alarm),    0);
    @(negedge CLK);
    RST = 0;
    applyStimulus(0, 0, 0);
  endtask

  function automatic vec_t mk(input logic m, input logic e, input logic r,
                              input logic v, input int c, input logic a);
    vec_t t;
    t.m = m; t.e = e; t.r = r; t.expValid = v; t.expCount = c; t.expAlarm = a;
    return t;
  endfunction

  initial begin
    Match = 0; Enable = 0; Rd_Ready = 0; RST = 1;

    // Reset mid-window after a completed report.
    doReset();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < WIN; i++) applyStimulus(i % 3 == 0 && i < 9, 1, 0);
    checkValue("pre.valid", int'(Rd_Valid), 1);
    checkValue("pre.count", int'(Rd_Count), 3);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    doReset();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < WIN; i++) applyStimulus(0, 1, 0);
    checkValue("rstwin.valid", int'(Rd_Valid), 1);
    checkValue("rstwin.count", int'(Rd_Count), 0);
    checkValue("rstwin.alarm", int'(Alarm),    0);

    // Basic windows from a table.
    doReset();
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    for (int i = 0; i < WIN - 1; i++) vecs.push_back(mk(i == 1 || i == 4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 3, 1));
    for (int i = 0; i < WIN - 1; i++) vecs.push_back(mk(i == 5, 1, 1, 0, 3, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].m, vecs[i].e, vecs[i].r);
      checkValue($sformatf("vec%0d.valid", i), int'(Rd_Valid), int'(vecs[i].expValid));
      checkValue($sformatf("vec%0d.count", i), int'(Rd_Count), vecs[i].expCount);
      checkValue($sformatf("vec%0d.alarm", i), int'(Alarm),    int'(vecs[i].expAlarm));
    end

    // Backpressure across two windows.
    doReset();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < WIN; i++) applyStimulus(i < 2, 1, 0);
    checkValue("bp1.count", int'(Rd_Count), 2);
    checkValue("bp1.alarm", int'(Alarm),    0);
    for (int i = 0; i < WIN; i++) applyStimulus(i < 5, 1, 0);
    checkValue("bp2.valid", int'(Rd_Valid), 1);
    checkValue("bp2.count", int'(Rd_Count), 2);
    checkValue("bp2.drop",  int'(Rd_Drop),  1);
    checkValue("bp2.alarm", int'(Alarm),    1);

    // Accept and close on the same edge.
    doReset();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < WIN; i++) applyStimulus(i < 2, 1, 0);
    for (int i = 0; i < WIN; i++) applyStimulus(i < 4, 1, i == WIN - 1);
    checkValue("sim.valid", int'(Rd_Valid), 1);
    checkValue("sim.count", int'(Rd_Count), 4);
    checkValue("sim.drop",  int'(Rd_Drop),  0);

    // Saturation on the 20-cycle instance.
    doReset();
    applyStimulus(1, 1, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1);
    checkValue("sat.valid", int'(satValid), 1);
    checkValue("sat.count", int'(satCount), 15);
    checkValue("sat.alarm", int'(satAlarm), 1);
    checkValue("sat.drop",  int'(satDrop),  0);

    // Abort mid-window, then a fresh window.
    doReset();
    applyStimulus(0, 1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(i < 4, 1, 1);
    applyStimulus(0, 0, 1);
    checkValue("abort.valid", int'(Rd_Valid), 0);
    checkValue("abort.alarm", int'(Alarm),    0);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < WIN - 1; i++) applyStimulus(i == 2, 1, 0);
    checkValue("abort.early", int'(Rd_Valid), 0);
    applyStimulus(0, 1, 0);
    checkValue("abort.valid2", int'(Rd_Valid), 1);
    checkValue("abort.count2", int'(Rd_Count), 1);
    checkValue("abort.alarm2", int'(Alarm),    0);

    // Randomized run against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 4, $urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
